// File: rtl/accumulate_sequencer.sv
// accumulate_sequencer: debounces the Add/Clear pushbuttons and drives the
// accumulator's enable/clear. One Acc_en strobe per debounced Add press,
// operand snapshot in Acc_x, saturating accepted-add count, sticky overflow.
// Optional build macro ACCUMULATE_SEQ_OVF_BLOCK_EN: refuse adds that would
// carry out of the accumulator instead of letting them wrap.
module accumulate_sequencer #(
  parameter int W               = 16,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Add_n,
  input  logic             Clear_n,
  input  logic [W-1:0]     X,
  input  logic [W-1:0]     Acc_sum,
  output logic             Acc_en,
  output logic             Acc_clr,
  output logic [W-1:0]     Acc_x,
  output logic [CNT_W-1:0] Count,
  output logic             Overflow,
  output logic             Busy
);

  localparam int DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, ISSUE, RELEASE} state_t;

  state_t        state, state_nx;
  logic [1:0]    add_sync, clr_sync;
  logic          add_s, clr_s;
  logic [DW-1:0] db_cnt;
  logic          db_clr, db_inc;
  logic          go, take, carry;

  assign add_s = add_sync[1];
  assign clr_s = clr_sync[1];

  // Unsigned a+b overflows W bits exactly when a > ~b; avoids a W+1 adder.
  assign carry = (Acc_sum > ~X);

`ifdef ACCUMULATE_SEQ_OVF_BLOCK_EN
  assign take = go & ~carry;
`else
  assign take = go;
`endif

  // Two-flop synchronizers, preset high so released buttons read idle.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      add_sync <= 2'b11;
      clr_sync <= 2'b11;
    end else begin
      add_sync <= {add_sync[0], Add_n};
      clr_sync <= {clr_sync[0], Clear_n};
    end
  end

  // State register; Busy tracks the registered state.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
      Busy  <= 1'b0;
    end else begin
      state <= state_nx;
      Busy  <= (state_nx != IDLE);
    end
  end

  // Next-state and debounce-counter control; Clear overrides everything.
  always_comb begin
    state_nx = state;
    db_clr   = 1'b0;
    db_inc   = 1'b0;
    go       = 1'b0;
    if (!clr_s) begin
      state_nx = IDLE;
      db_clr   = 1'b1;
    end else begin
      case (state)
        IDLE: if (!add_s) begin
          state_nx = SETTLE;
          db_clr   = 1'b1;
        end
        SETTLE: begin
          if (add_s) state_nx = IDLE;
          else if (db_cnt == DB_LAST) begin
            state_nx = ISSUE;
            go       = 1'b1;
          end else db_inc = 1'b1;
        end
        ISSUE: begin
          state_nx = RELEASE;
          db_clr   = 1'b1;
        end
        RELEASE: begin
          if (!add_s) db_clr = 1'b1;
          else if (db_cnt == DB_LAST) state_nx = IDLE;
          else db_inc = 1'b1;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Datapath-facing registers: strobe, operand snapshot, count, overflow.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      db_cnt   <= '0;
      Acc_en   <= 1'b0;
      Acc_clr  <= 1'b0;
      Acc_x    <= '0;
      Count    <= '0;
      Overflow <= 1'b0;
    end else begin
      Acc_clr <= ~clr_s;
      Acc_en  <= take;
      if (db_clr)      db_cnt <= '0;
      else if (db_inc) db_cnt <= db_cnt + DW'(1);
      if (go) Acc_x <= X;
      if (!clr_s) begin
        Count    <= '0;
        Overflow <= 1'b0;
      end else begin
        if (go && carry) Overflow <= 1'b1;
        if (take && (Count != '1)) Count <= Count + CNT_W'(1);
      end
    end
  end

endmodule
